control_unit_legv8: RTL and testbench

- Multi-cycle LEGv8 controller: fetches instructions, decodes a core subset, and drives every control input of the 64-bit LEGv8 datapath (register file, B mux, ALU, tri-state buffers, 256x64 RAM).
- Owns the program counter and consumes the ALU status flags for conditional branches.
- Sits between the instruction memory and the datapath; it is the producer of the datapath's control word.

---
 rtl/legv8_pkg.sv | 43 ++++
 rtl/instr_decode_legv8.sv | 87 ++++++++
 rtl/control_unit_legv8.sv | 188 ++++++++++++++++++
 tb/tb_control_unit_legv8.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode constants, ALU function codes, controller
// state and instruction-class enumerations.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    IC_ALU_R,
    IC_ALU_I,
    IC_LDUR,
    IC_STUR,
    IC_CBZ,
    IC_CBNZ,
    IC_B,
    IC_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/instr_decode_legv8.sv
// Combinational LEGv8 decoder: instruction class, ALU function, register
// fields, datapath immediate and branch byte offset from the held instruction.
module instr_decode_legv8
  import legv8_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [2:0]  o_cls,
  output logic [4:0]  o_fs,
  output logic        o_sub,
  output logic [4:0]  o_sa,
  output logic [4:0]  o_sb,
  output logic [4:0]  o_da,
  output logic [63:0] o_k,
  output logic [63:0] o_br_off
);

  iclass_t     w_cls;
  logic [4:0]  w_fs;
  logic        w_sub;
  logic [10:0] w_op11;
  logic [9:0]  w_op10;
  logic [7:0]  w_op8;
  logic [5:0]  w_op6;

  assign w_op11 = i_ir[31:21];
  assign w_op10 = i_ir[31:22];
  assign w_op8  = i_ir[31:24];
  assign w_op6  = i_ir[31:26];

  // Longest opcode first so a short pattern never shadows a longer one.
  always_comb begin
    w_cls = IC_ILLEGAL;
    w_fs  = FS_ADD;
    w_sub = 1'b0;
    if (w_op11 == OP_ADD) begin
      w_cls = IC_ALU_R;
    end else if (w_op11 == OP_SUB) begin
      w_cls = IC_ALU_R;
      w_fs  = FS_SUB;
      w_sub = 1'b1;
    end else if (w_op11 == OP_AND) begin
      w_cls = IC_ALU_R;
      w_fs  = FS_AND;
    end else if (w_op11 == OP_ORR) begin
      w_cls = IC_ALU_R;
      w_fs  = FS_ORR;
    end else if (w_op11 == OP_LDUR) begin
      w_cls = IC_LDUR;
    end else if (w_op11 == OP_STUR) begin
      w_cls = IC_STUR;
    end else if (w_op10 == OP_ADDI) begin
      w_cls = IC_ALU_I;
    end else if (w_op10 == OP_SUBI) begin
      w_cls = IC_ALU_I;
      w_fs  = FS_SUB;
      w_sub = 1'b1;
    end else if (w_op8 == OP_CBZ) begin
      w_cls = IC_CBZ;
    end else if (w_op8 == OP_CBNZ) begin
      w_cls = IC_CBNZ;
    end else if (w_op6 == OP_B) begin
      w_cls = IC_B;
    end
  end

  always_comb begin
    o_k      = 64'd0;
    o_br_off = 64'd0;
    unique case (w_cls)
      IC_ALU_I:        o_k = {52'd0, i_ir[21:10]};
      IC_LDUR,
      IC_STUR:         o_k = {{55{i_ir[20]}}, i_ir[20:12]};
      IC_CBZ, IC_CBNZ: o_br_off = {{43{i_ir[23]}}, i_ir[23:5], 2'b00};
      IC_B:            o_br_off = {{36{i_ir[25]}}, i_ir[25:0], 2'b00};
      default: ;
    endcase
  end

  // CB-type reads Rt through port A; STUR reads Rt through port B.
  assign o_sa  = (w_cls == IC_CBZ || w_cls == IC_CBNZ) ? i_ir[4:0] : i_ir[9:5];
  assign o_sb  = (w_cls == IC_STUR) ? i_ir[4:0] : i_ir[20:16];
  assign o_da  = i_ir[4:0];
  assign o_cls = w_cls;
  assign o_fs  = w_fs;
  assign o_sub = w_sub;

endmodule

// File: rtl/control_unit_legv8.sv
// Multi-cycle LEGv8 controller (FETCH/DECODE/EXEC/MEM) driving the datapath
// control word. Define HALT_ON_ILLEGAL_EN to stop on unrecognised opcodes.
module control_unit_legv8
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        imem_req,
  output logic [63:0] pc,
  input  logic [3:0]  stat,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  FS,
  output logic        c_out,
  output logic [63:0] k,
  output logic        B_sel,
  output logic        W_reg,
  output logic        W_ram,
  output logic        B_en,
  output logic        alu_en,
  output logic        D_en,
  output logic        ram_en,
  output logic        halted
);

  state_t      r_state;
  logic [63:0] r_pc;
  logic [31:0] r_ir;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic        w_ir_load;
  logic        w_taken;

  logic [2:0]  w_cls_raw;
  iclass_t     w_cls;
  logic [4:0]  w_dec_fs;
  logic        w_dec_sub;
  logic [4:0]  w_dec_sa;
  logic [4:0]  w_dec_sb;
  logic [4:0]  w_dec_da;
  logic [63:0] w_dec_k;
  logic [63:0] w_dec_br_off;
  logic        w_unused_stat;

  instr_decode_legv8 u_decode (
    .i_ir     (r_ir),
    .o_cls    (w_cls_raw),
    .o_fs     (w_dec_fs),
    .o_sub    (w_dec_sub),
    .o_sa     (w_dec_sa),
    .o_sb     (w_dec_sb),
    .o_da     (w_dec_da),
    .o_k      (w_dec_k),
    .o_br_off (w_dec_br_off)
  );

  assign w_cls         = iclass_t'(w_cls_raw);
  assign w_unused_stat = ^stat[3:1];
  assign pc            = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ir_load) r_ir <= instr;
    end
  end

  // Outputs are held at zero while rst is high so that an instruction
  // abandoned by reset never commits a register or RAM write.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_load   = 1'b0;
    w_taken     = 1'b0;
    imem_req    = 1'b0;
    DA          = 5'd0;
    SA          = 5'd0;
    SB          = 5'd0;
    FS          = 5'd0;
    c_out       = 1'b0;
    k           = 64'd0;
    B_sel       = 1'b0;
    W_reg       = 1'b0;
    W_ram       = 1'b0;
    B_en        = 1'b0;
    alu_en      = 1'b0;
    D_en        = 1'b0;
    ram_en      = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      unique case (r_state)
        FETCH: begin
          imem_req = 1'b1;
          if (instr_valid) begin
            w_ir_load   = 1'b1;
            w_state_nxt = DECODE;
          end
        end
        DECODE: begin
          SA          = w_dec_sa;
          SB          = w_dec_sb;
          DA          = w_dec_da;
          w_state_nxt = EXEC;
        end
        EXEC: begin
          SA          = w_dec_sa;
          SB          = w_dec_sb;
          DA          = w_dec_da;
          w_state_nxt = FETCH;
          w_pc_nxt    = r_pc + PC_STEP;
          unique case (w_cls)
            IC_ALU_R, IC_ALU_I: begin
              FS     = w_dec_fs;
              c_out  = w_dec_sub;
              B_sel  = (w_cls == IC_ALU_I);
              k      = w_dec_k;
              alu_en = 1'b1;
              W_reg  = (w_dec_da != XZR);
            end
            IC_LDUR: begin
              FS          = FS_ADD;
              B_sel       = 1'b1;
              k           = w_dec_k;
              ram_en      = 1'b1;
              w_state_nxt = MEM;
              w_pc_nxt    = r_pc;
            end
            IC_STUR: begin
              FS     = FS_ADD;
              B_sel  = 1'b1;
              k      = w_dec_k;
              ram_en = 1'b1;
              B_en   = 1'b1;
              W_ram  = 1'b1;
            end
            IC_CBZ, IC_CBNZ: begin
              FS      = FS_ADD;
              B_sel   = 1'b1;
              w_taken = (w_cls == IC_CBZ) ? stat[0] : !stat[0];
              if (w_taken) w_pc_nxt = r_pc + w_dec_br_off;
            end
            IC_B: begin
              w_pc_nxt = r_pc + w_dec_br_off;
            end
            default: begin
`ifdef HALT_ON_ILLEGAL_EN
              w_state_nxt = HALT;
              w_pc_nxt    = r_pc;
`endif
            end
          endcase
        end
        MEM: begin
          SA          = w_dec_sa;
          DA          = w_dec_da;
          FS          = FS_ADD;
          B_sel       = 1'b1;
          k           = w_dec_k;
          ram_en      = 1'b1;
          D_en        = 1'b1;
          W_reg       = (w_dec_da != XZR);
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = FETCH;
        end
        HALT: begin
`ifdef HALT_ON_ILLEGAL_EN
          halted = 1'b1;
`endif
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_legv8.sv
// Directed bench for control_unit_legv8: walks a short program through the
// controller and checks the control word and PC at each cycle boundary.
module tb_control_unit_legv8;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic [63:0] pc;
  logic [3:0]  stat;
  logic [4:0]  DA, SA, SB, FS;
  logic        c_out;
  logic [63:0] k;
  logic        B_sel, W_reg, W_ram, B_en, alu_en, D_en, ram_en, halted;

  int n_chk  = 0;
  int n_fail = 0;

  control_unit_legv8 dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .imem_req    (imem_req),
    .pc          (pc),
    .stat        (stat),
    .DA          (DA),
    .SA          (SA),
    .SB          (SB),
    .FS          (FS),
    .c_out       (c_out),
    .k           (k),
    .B_sel       (B_sel),
    .W_reg       (W_reg),
    .W_ram       (W_ram),
    .B_en        (B_en),
    .alu_en      (alu_en),
    .D_en        (D_en),
    .ram_en      (ram_en),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("bus_excl", {63'd0, (int'(B_en) + int'(alu_en) + int'(D_en)) <= 1}, 64'd1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one instruction in FETCH; returns at the negedge inside DECODE.
  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_ready", {63'd0, imem_req}, 64'd1);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = 32'd0;
  endtask

  logic [31:0] i_add, i_addi, i_ldur, i_stur, i_cbz, i_cbnz, i_b2, i_bm1;

  initial begin
    i_add  = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3};      // ADD X3,X1,X2
    i_addi = {10'b1001000100, 12'd5, 5'd1, 5'd31};           // ADDI X31,X1,#5
    i_ldur = {11'b11111000010, 9'h1F8, 2'b00, 5'd2, 5'd4};   // LDUR X4,[X2,#-8]
    i_stur = {11'b11111000000, 9'd16, 2'b00, 5'd7, 5'd6};    // STUR X6,[X7,#16]
    i_cbz  = {8'b10110100, 19'h7FFFE, 5'd5};                 // CBZ X5,#-2
    i_cbnz = {8'b10110101, 19'h7FFFE, 5'd5};                 // CBNZ X5,#-2
    i_b2   = {6'b000101, 26'd2};                             // B #2
    i_bm1  = {6'b000101, 26'h3FFFFFF};                       // B #-1

    rst = 1'b1; instr = 32'd0; instr_valid = 1'b0; stat = 4'd0;
    repeat (2) tick();
    chk("rst_pc", pc, 64'd0);
    chk("rst_wreg", {63'd0, W_reg}, 64'd0);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0;
    #1;
    chk("fetch_req", {63'd0, imem_req}, 64'd1);

    // ADD with a two-cycle fetch stall
    tick();
    chk("stall1_pc", pc, 64'd0);
    tick();
    chk("stall2_req", {63'd0, imem_req}, 64'd1);
    issue(i_add);
    chk("add_dec_wreg", {63'd0, W_reg}, 64'd0);
    chk("add_dec_da", {59'd0, DA}, 64'd3);
    chk("add_dec_req", {63'd0, imem_req}, 64'd0);
    tick();
    chk("add_ex_wreg", {63'd0, W_reg}, 64'd1);
    chk("add_ex_da", {59'd0, DA}, 64'd3);
    chk("add_ex_sa", {59'd0, SA}, 64'd1);
    chk("add_ex_sb", {59'd0, SB}, 64'd2);
    chk("add_ex_fs", {59'd0, FS}, 64'b01000);
    chk("add_ex_alu", {63'd0, alu_en}, 64'd1);
    chk("add_ex_bsel", {63'd0, B_sel}, 64'd0);
    chk("add_ex_pc", pc, 64'd0);
    tick();
    chk("add_pc", pc, 64'd4);
    chk("add_post_wreg", {63'd0, W_reg}, 64'd0);

    // ADDI to XZR: no write
    issue(i_addi);
    chk("addi_dec_wreg", {63'd0, W_reg}, 64'd0);
    tick();
    chk("addi_ex_wreg", {63'd0, W_reg}, 64'd0);
    chk("addi_ex_k", k, 64'd5);
    chk("addi_ex_bsel", {63'd0, B_sel}, 64'd1);
    chk("addi_ex_fs", {59'd0, FS}, 64'b01000);
    tick();
    chk("addi_pc", pc, 64'd8);

    // LDUR with negative displacement
    issue(i_ldur);
    tick();
    chk("ldur_ex_ram", {63'd0, ram_en}, 64'd1);
    chk("ldur_ex_k", k, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_ex_sa", {59'd0, SA}, 64'd2);
    chk("ldur_ex_wreg", {63'd0, W_reg}, 64'd0);
    chk("ldur_ex_den", {63'd0, D_en}, 64'd0);
    tick();
    chk("ldur_mem_den", {63'd0, D_en}, 64'd1);
    chk("ldur_mem_wreg", {63'd0, W_reg}, 64'd1);
    chk("ldur_mem_da", {59'd0, DA}, 64'd4);
    chk("ldur_mem_ram", {63'd0, ram_en}, 64'd1);
    chk("ldur_mem_k", k, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_mem_pc", pc, 64'd8);
    tick();
    chk("ldur_pc", pc, 64'h0C);

    // STUR
    issue(i_stur);
    tick();
    chk("stur_ex_wram", {63'd0, W_ram}, 64'd1);
    chk("stur_ex_ben", {63'd0, B_en}, 64'd1);
    chk("stur_ex_alu", {63'd0, alu_en}, 64'd0);
    chk("stur_ex_sb", {59'd0, SB}, 64'd6);
    chk("stur_ex_sa", {59'd0, SA}, 64'd7);
    chk("stur_ex_k", k, 64'd16);
    chk("stur_ex_wreg", {63'd0, W_reg}, 64'd0);
    tick();
    chk("stur_pc", pc, 64'h10);
    chk("stur_post_wram", {63'd0, W_ram}, 64'd0);

    // CBZ taken from 0x10
    issue(i_cbz);
    stat = 4'b0001;
    tick();
    chk("cbz_ex_sa", {59'd0, SA}, 64'd5);
    chk("cbz_ex_k", k, 64'd0);
    chk("cbz_ex_bsel", {63'd0, B_sel}, 64'd1);
    chk("cbz_ex_wreg", {63'd0, W_reg}, 64'd0);
    tick();
    chk("cbz_taken_pc", pc, 64'h08);

    // B #2 back to 0x10
    stat = 4'b0000;
    issue(i_b2);
    tick();
    chk("b_ex_alu", {63'd0, alu_en}, 64'd0);
    chk("b_ex_ram", {63'd0, ram_en}, 64'd0);
    tick();
    chk("b_pc", pc, 64'h10);

    // CBZ not taken, then CBNZ taken
    issue(i_cbz);
    stat = 4'b0000;
    tick();
    tick();
    chk("cbz_nt_pc", pc, 64'h14);
    issue(i_cbnz);
    stat = 4'b0000;
    tick();
    tick();
    chk("cbnz_taken_pc", pc, 64'h0C);

    // Reset during MEM of LDUR abandons the load
    issue(i_ldur);
    tick();
    tick();
    chk("rstmem_pre_wreg", {63'd0, W_reg}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rstmem_wreg", {63'd0, W_reg}, 64'd0);
    chk("rstmem_wram", {63'd0, W_ram}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmem_pc", pc, 64'd0);
    chk("rstmem_req", {63'd0, imem_req}, 64'd1);
    chk("rstmem_post_wreg", {63'd0, W_reg}, 64'd0);

    // PC wrap-around in both directions
    issue(i_bm1);
    tick();
    tick();
    chk("wrap_back_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    issue(i_b2);
    tick();
    tick();
    chk("wrap_fwd_pc", pc, 64'h4);

    // Illegal opcode
    issue(32'hFFFF_FFFF);
    tick();
    chk("ill_ex_wreg", {63'd0, W_reg}, 64'd0);
    chk("ill_ex_wram", {63'd0, W_ram}, 64'd0);
    chk("ill_ex_ram", {63'd0, ram_en}, 64'd0);
`ifdef HALT_ON_ILLEGAL_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_flag", {63'd0, halted}, 64'd1);
      chk("halt_pc", pc, 64'h4);
      chk("halt_req", {63'd0, imem_req}, 64'd0);
    end
`else
    tick();
    chk("ill_nop_pc", pc, 64'h8);
    chk("ill_halted", {63'd0, halted}, 64'd0);
    chk("ill_nop_req", {63'd0, imem_req}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1);
  end

endmodule
